// File: rtl/vga_capture.sv
// vga_capture: VGA receiver. It registers the 12-bit RGB stream and the HS/VS
// syncs, recovers the raster position from the sync leading edges, and checks
// the line and frame timing. Once the timing is locked it emits whole frames
// as a valid-qualified pixel stream with X/Y coordinates.
module vga_capture #(
    parameter int unsigned H_SYNC_CYC   = 96,
    parameter int unsigned H_SYNC_BACK  = 48,
    parameter int unsigned H_ACT        = 640,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_SYNC_CYC   = 2,
    parameter int unsigned V_SYNC_BACK  = 33,
    parameter int unsigned V_ACT        = 480,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned SYNC_ACT_LOW = 1
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [3:0]  iVGA_R,
    input  logic [3:0]  iVGA_G,
    input  logic [3:0]  iVGA_B,
    input  logic        iVGA_H_SYNC,
    input  logic        iVGA_V_SYNC,
    input  logic        iEnable,
    output logic [11:0] oPixel,
    output logic        oPixel_Valid,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oFrameStart,
    output logic        oFrameDone,
    output logic        oLocked,
    output logic        oHErr,
    output logic        oVErr,
    output logic [15:0] oLine_Len,
    output logic [15:0] oFrame_Lines
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned H_START = H_SYNC_CYC + H_SYNC_BACK;
    localparam int unsigned H_END   = H_START + H_ACT - 1;
    localparam int unsigned V_START = V_SYNC_CYC + V_SYNC_BACK;
    localparam int unsigned V_END   = V_START + V_ACT - 1;

    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_PRE   = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W:0]     H_TOT_W   = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]     V_TOT_W   = (CNT_W+1)'(V_TOTAL);
    localparam logic [CNT_W-1:0]   H_START_W = CNT_W'(H_START);
    localparam logic [CNT_W-1:0]   H_END_W   = CNT_W'(H_END);
    localparam logic [CNT_W-1:0]   V_START_W = CNT_W'(V_START);
    localparam logic [CNT_W-1:0]   V_END_W   = CNT_W'(V_END);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACT - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACT - 1);
    localparam logic               ACT_LOW   = (SYNC_ACT_LOW != 0);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Input stage
    logic [3:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, hs_prev_q, vs_prev_q;

    // Raster tracking
    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic             vs_pend_q, vs_pend_d;

    // Lock FSM and capture gating
    state_e state_q, state_d;
    logic   herr_seen_q, herr_seen_d;
    logic   cap_q, cap_d;

    // Output registers
    logic [11:0]        pixel_q;
    logic               valid_q, fstart_q, fdone_q, locked_q, herr_q, verr_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic [CNT_W-1:0]   line_len_q, frame_lines_q;

    // Edge detection, error conditions and window decode
    logic             hs_lead_c, vs_lead_c, boundary_c;
    logic [CNT_W:0]   hc_inc_c, vc_inc_c;
    logic             h_err_c, v_err_c;
    logic             h_act_c, v_act_c, valid_c;
    logic [COORD_W-1:0] x_c, y_c;

    // Register RGB and sync once; syncs stored as 1 = active
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_q       <= 4'd0;
            g_q       <= 4'd0;
            b_q       <= 4'd0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            r_q       <= iVGA_R;
            g_q       <= iVGA_G;
            b_q       <= iVGA_B;
            hs_q      <= iVGA_H_SYNC ^ ACT_LOW;
            vs_q      <= iVGA_V_SYNC ^ ACT_LOW;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
        end
    end

    // Sync edges, raster counters and timing error conditions
    always_comb begin
        hs_lead_c  = hs_q & ~hs_prev_q;
        vs_lead_c  = vs_q & ~vs_prev_q;
        boundary_c = hs_lead_c & (vs_pend_q | vs_lead_c);
        hc_inc_c   = {1'b0, hc_q} + (CNT_W+1)'(1);
        vc_inc_c   = {1'b0, vc_q} + (CNT_W+1)'(1);
        // A line that runs into counter saturation is flagged once, on entry
        h_err_c    = (hs_lead_c & (hc_inc_c != H_TOT_W)) | (~hs_lead_c & (hc_q == CNT_PRE));
        v_err_c    = boundary_c & (vc_inc_c != V_TOT_W);

        hc_d = hc_q;
        if (hs_lead_c)            hc_d = '0;
        else if (hc_q != CNT_MAX) hc_d = hc_inc_c[CNT_W-1:0];

        vc_d = vc_q;
        if (boundary_c)                        vc_d = '0;
        else if (hs_lead_c && vc_q != CNT_MAX) vc_d = vc_inc_c[CNT_W-1:0];

        vs_pend_d = vs_pend_q;
        if (boundary_c)     vs_pend_d = 1'b0;
        else if (vs_lead_c) vs_pend_d = 1'b1;
    end

    // Lock FSM next state and frame capture decision
    always_comb begin
        state_d     = state_q;
        herr_seen_d = herr_seen_q;
        cap_d       = cap_q;
        case (state_q)
            SEARCH: begin
                if (boundary_c) begin
                    state_d     = MEASURE;
                    herr_seen_d = 1'b0;
                end
            end
            MEASURE: begin
                if (boundary_c) begin
                    state_d     = (herr_seen_q | h_err_c | v_err_c) ? MEASURE : LOCKED;
                    herr_seen_d = 1'b0;
                end else if (h_err_c) begin
                    herr_seen_d = 1'b1;
                end
            end
            LOCKED: begin
                if (h_err_c | v_err_c) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
        // Capture is decided only at a boundary, but dropped the moment lock is lost
        if (boundary_c)              cap_d = (state_d == LOCKED) & iEnable;
        else if (state_d != LOCKED)  cap_d = 1'b0;
    end

    // Active window on the s1 sample's own raster position
    always_comb begin
        h_act_c = (hc_d >= H_START_W) && (hc_d <= H_END_W);
        v_act_c = (vc_d >= V_START_W) && (vc_d <= V_END_W);
        valid_c = h_act_c & v_act_c & cap_d;
        x_c     = COORD_W'(hc_d - H_START_W);
        y_c     = COORD_W'(vc_d - V_START_W);
    end

    // Raster counters, FSM state and capture flag
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hc_q        <= '0;
            vc_q        <= '0;
            vs_pend_q   <= 1'b0;
            state_q     <= SEARCH;
            herr_seen_q <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            vs_pend_q   <= vs_pend_d;
            state_q     <= state_d;
            herr_seen_q <= herr_seen_d;
            cap_q       <= cap_d;
        end
    end

    // Output stage: pixel stream, status and measurements
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pixel_q       <= 12'd0;
            valid_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            fstart_q      <= 1'b0;
            fdone_q       <= 1'b0;
            locked_q      <= 1'b0;
            herr_q        <= 1'b0;
            verr_q        <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            valid_q  <= valid_c;
            if (valid_c) begin
                pixel_q <= {b_q, g_q, r_q};
                x_q     <= x_c;
                y_q     <= y_c;
            end
            fstart_q <= valid_c && (x_c == '0) && (y_c == '0);
            fdone_q  <= valid_c && (x_c == X_LAST) && (y_c == Y_LAST);
            locked_q <= (state_d == LOCKED);
            herr_q   <= h_err_c & (state_q != SEARCH);
            verr_q   <= v_err_c & (state_q != SEARCH);
            if (hs_lead_c)  line_len_q    <= hc_inc_c[CNT_W-1:0];
            if (boundary_c) frame_lines_q <= vc_inc_c[CNT_W-1:0];
        end
    end

    assign oPixel       = pixel_q;
    assign oPixel_Valid = valid_q;
    assign oX           = x_q;
    assign oY           = y_q;
    assign oFrameStart  = fstart_q;
    assign oFrameDone   = fdone_q;
    assign oLocked      = locked_q;
    assign oHErr        = herr_q;
    assign oVErr        = verr_q;
    assign oLine_Len    = line_len_q;
    assign oFrame_Lines = frame_lines_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench for vga_capture on a reduced 20x12 raster
// (8x6 active). A raster generator pushes every pixel that must be captured
// into a scoreboard queue; a monitor pops and compares each valid output.
module tb_vga_capture;

    localparam int HSC = 4, HSB = 3, HA = 8, HT = 20;
    localparam int VSC = 2, VSB = 2, VA = 6, VT = 12;
    localparam int HS0 = HSC + HSB, HE0 = HS0 + HA - 1;
    localparam int VS0 = VSC + VSB, VE0 = VS0 + VA - 1;

    typedef struct packed {
        logic [23:0] cyc;
        logic [11:0] pix;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic        fd;
    } exp_t;

    logic        clk, rst_n, hs, vs, en;
    logic [3:0]  r, g, b;
    logic [11:0] oPixel;
    logic        oPixel_Valid, oFrameStart, oFrameDone, oLocked, oHErr, oVErr;
    logic [9:0]  oX, oY;
    logic [15:0] oLine_Len, oFrame_Lines;

    int   cyc = 0;
    int   n_checks = 0, n_pass = 0, n_fail = 0;
    int   n_valid = 0, fs_cnt = 0, fd_cnt = 0, herr_cnt = 0, verr_cnt = 0;
    exp_t exp_q[$];

    vga_capture #(
        .H_SYNC_CYC(HSC), .H_SYNC_BACK(HSB), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC_CYC(VSC), .V_SYNC_BACK(VSB), .V_ACT(VA), .V_TOTAL(VT),
        .SYNC_ACT_LOW(1)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
        .iVGA_H_SYNC(hs), .iVGA_V_SYNC(vs), .iEnable(en),
        .oPixel(oPixel), .oPixel_Valid(oPixel_Valid), .oX(oX), .oY(oY),
        .oFrameStart(oFrameStart), .oFrameDone(oFrameDone), .oLocked(oLocked),
        .oHErr(oHErr), .oVErr(oVErr), .oLine_Len(oLine_Len), .oFrame_Lines(oFrame_Lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pops one expected entry per valid output; also counts pulses
    task automatic monitor();
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (oHErr) herr_cnt++;
                if (oVErr) verr_cnt++;
                if (oPixel_Valid) begin
                    n_valid++;
                    if (oFrameStart) fs_cnt++;
                    if (oFrameDone) fd_cnt++;
                    got.cyc = 24'(cyc);
                    got.pix = oPixel;
                    got.x   = oX;
                    got.y   = oY;
                    got.fs  = oFrameStart;
                    got.fd  = oFrameDone;
                    if (exp_q.size() == 0) check("spurious_valid", 64'(oPixel_Valid), 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("pixel{cyc,pix,x,y,fs,fd}", 64'(got), 64'(e));
                    end
                end else if (oFrameStart || oFrameDone) begin
                    check("pulse_without_valid", 64'({oFrameStart, oFrameDone}), 64'd0);
                end
            end
        end
    endtask

    // Syncs inactive for n clocks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'b1; vs = 1'b1;
            {b, g, r} = 12'($urandom);
        end
    endtask

    // One frame of raster; negative line arguments disable the option
    task automatic drive_frame(input int lines, input bit cap, input int stretch_line,
                               input int en_lo_line, input int en_hi_line, input int rst_line);
        bit   abort;
        int   len;
        exp_t e;
        abort = 1'b0;
        for (int l = 0; l < lines; l++) begin
            len = (l == stretch_line) ? HT + 1 : HT;
            if (stretch_line >= 0 && l == stretch_line + 1) abort = 1'b1;
            if (l == en_lo_line) en = 1'b0;
            if (l == en_hi_line) en = 1'b1;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                hs = (c < HSC) ? 1'b0 : 1'b1;
                vs = (l < VSC) ? 1'b0 : 1'b1;
                {b, g, r} = 12'($urandom);
                if (l == rst_line && c == 10) begin
                    abort = 1'b1;
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_locked", 64'(oLocked), 64'd0);
                    check("rst_valid", 64'(oPixel_Valid), 64'd0);
                    check("rst_pixel", 64'(oPixel), 64'd0);
                    check("rst_x", 64'(oX), 64'd0);
                    check("rst_y", 64'(oY), 64'd0);
                    check("rst_line_len", 64'(oLine_Len), 64'd0);
                    check("rst_frame_lines", 64'(oFrame_Lines), 64'd0);
                    exp_q.delete();
                    #1 rst_n = 1'b1;
                end
                if (cap && !abort && c >= HS0 && c <= HE0 && l >= VS0 && l <= VE0) begin
                    e.cyc = 24'(cyc + 2);
                    e.pix = {b, g, r};
                    e.x   = 10'(c - HS0);
                    e.y   = 10'(l - VS0);
                    e.fs  = (c == HS0) && (l == VS0);
                    e.fd  = (c == HE0) && (l == VE0);
                    exp_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; hs = 1'b1; vs = 1'b1; {b, g, r} = 12'd0;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_locked", 64'(oLocked), 64'd0);
        check("reset_valid", 64'(oPixel_Valid), 64'd0);
        check("reset_line_len", 64'(oLine_Len), 64'd0);
        check("reset_frame_lines", 64'(oFrame_Lines), 64'd0);
        #1 rst_n = 1'b1;
        idle(5);

        // Nominal stream: lock at second boundary, capture the next frame
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        check("f1_not_locked", 64'(oLocked), 64'd0);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("f2_locked", 64'(oLocked), 64'd1);
        check("f2_line_len", 64'(oLine_Len), 64'(HT));
        check("f2_frame_lines", 64'(oFrame_Lines), 64'(VT));
        check("f2_valid_count", 64'(n_valid), 64'(HA * VA));
        check("f2_frame_start", 64'(fs_cnt), 64'd1);
        check("f2_frame_done", 64'(fd_cnt), 64'd1);
        check("f2_no_herr", 64'(herr_cnt), 64'd0);
        check("f2_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stretched line in active row 2 drops lock mid-frame
        drive_frame(VT, 1'b1, VS0 + 2, -1, -1, -1);
        check("stretch_herr", 64'(herr_cnt), 64'd1);
        check("stretch_unlocked", 64'(oLocked), 64'd0);
        check("stretch_no_done", 64'(fd_cnt), 64'd1);
        check("stretch_valid_count", 64'(n_valid), 64'(HA * VA + HA * 3));
        check("stretch_queue_empty", 64'(exp_q.size()), 64'd0);
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        check("relock_wait", 64'(oLocked), 64'd0);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("relock", 64'(oLocked), 64'd1);
        check("relock_done", 64'(fd_cnt), 64'd2);

        // Short frame while locked
        drive_frame(VT - 1, 1'b1, -1, -1, -1, -1);
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        check("short_verr", 64'(verr_cnt), 64'd1);
        check("short_frame_lines", 64'(oFrame_Lines), 64'(VT - 1));
        check("short_unlocked", 64'(oLocked), 64'd0);
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("short_relock", 64'(oLocked), 64'd1);
        check("short_done", 64'(fd_cnt), 64'd4);

        // Enable dropped then raised mid-frame
        drive_frame(VT, 1'b1, -1, VS0 + 2, -1, -1);
        check("en_current_done", 64'(fd_cnt), 64'd5);
        drive_frame(VT, 1'b0, -1, -1, VS0 + 1, -1);
        check("en_skipped", 64'(fd_cnt), 64'd5);
        check("en_still_locked", 64'(oLocked), 64'd1);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("en_resumed", 64'(fd_cnt), 64'd6);
        check("en_queue_empty", 64'(exp_q.size()), 64'd0);

        // HS held inactive long enough to saturate the line counter
        idle(70000);
        check("sat_herr", 64'(herr_cnt), 64'd2);
        check("sat_unlocked", 64'(oLocked), 64'd0);
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        check("sat_no_extra_herr", 64'(herr_cnt), 64'd2);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("sat_relock", 64'(oLocked), 64'd1);
        check("sat_done", 64'(fd_cnt), 64'd7);

        // Reset in the middle of an active line
        drive_frame(VT, 1'b1, -1, -1, -1, VS0 + 2);
        check("post_rst_unlocked", 64'(oLocked), 64'd0);
        drive_frame(VT, 1'b0, -1, -1, -1, -1);
        check("post_rst_measure", 64'(oLocked), 64'd0);
        check("post_rst_no_done", 64'(fd_cnt), 64'd7);
        drive_frame(VT, 1'b1, -1, -1, -1, -1);
        check("post_rst_relock", 64'(oLocked), 64'd1);
        check("post_rst_done", 64'(fd_cnt), 64'd8);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_verr", 64'(verr_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- VGA receiver that samples a 12-bit RGB VGA stream with HS/VS in the pixel clock domain.
- Recovers raster position from the sync edges and verifies the timing against nominal parameters.
- Once the timing is verified, emits whole captured frames as a valid-qualified pixel stream with X/Y coordinates.
- Sits at the far end of the VGA output path. Used for loopback self-test of the display pipeline and for feeding a frame-buffer writer.

Parameters:
H_SYNC_CYC, 96, HS pulse width in clocks
H_SYNC_BACK, 48, horizontal back porch in clocks
H_ACT, 640, active pixels per line (max 1023)
H_TOTAL, 800, clocks per line
V_SYNC_CYC, 2, VS pulse width in lines
V_SYNC_BACK, 33, vertical back porch in lines
V_ACT, 480, active lines per frame (max 1023)
V_TOTAL, 525, lines per frame
SYNC_ACT_LOW, 1, 1 = HS/VS active-low; 0 = active-high

Ports:
iVGA_CLK  in  1  pixel clock
iRST_n  in  1  reset
iVGA_R  in  4  red
iVGA_G  in  4  green
iVGA_B  in  4  blue
iVGA_H_SYNC  in  1  horizontal sync
iVGA_V_SYNC  in  1  vertical sync
iEnable  in  1  capture enable, sampled at frame boundary
oPixel  out  12  captured pixel {B,G,R}
oPixel_Valid  out  1  oPixel/oX/oY valid
oX  out  10  active column
oY  out  10  active row
oFrameStart  out  1  pulse with first pixel of captured frame
oFrameDone  out  1  pulse with last pixel of captured frame
oLocked  out  1  timing verified
oHErr  out  1  pulse: bad line length
oVErr  out  1  pulse: bad frame line count
oLine_Len  out  16  last measured line length in clocks
oFrame_Lines  out  16  last measured lines per frame

Behaviour:
- Reset:
  - iRST_n is asynchronous, active-low; clock is iVGA_CLK.
  - All outputs and state reset to 0; FSM resets to SEARCH.
- Input stage:
  - RGB, HS and VS are registered once (stage s1).
  - Polarity is normalised per SYNC_ACT_LOW, so internal hs/vs are 1 when active.
  - Leading edge = active in s1 and inactive in the previous s1 sample.
- Horizontal counter (16-bit):
  - hc <= 0 on an HS leading edge, else hc+1.
  - hc saturates at 0xFFFF. Saturation counts as a line-length error.
- Line length measurement:
  - On an HS leading edge: oLine_Len <= hc+1.
  - hErr condition: (hc+1) != H_TOTAL.
- Vertical handling:
  - A VS leading edge sets vs_pend.
  - On an HS leading edge with vs_pend set (or VS and HS leading edges in the same cycle):
    - oFrame_Lines <= vc+1; vc <= 0; vs_pend clears; this is the frame boundary.
    - vErr condition: (vc+1) != V_TOTAL.
  - Any other HS leading edge: vc <= vc+1, saturating at 0xFFFF.
- FSM SEARCH / MEASURE / LOCKED:
  - SEARCH -> MEASURE at the first frame boundary.
  - MEASURE -> LOCKED at the next frame boundary if no hErr occurred during the frame and the vErr condition is false; otherwise stay in MEASURE and restart measurement.
  - LOCKED -> SEARCH on any hErr or on a frame boundary with vErr.
  - oLocked = (state == LOCKED).
- Error pulses:
  - oHErr / oVErr are 1-cycle pulses, asserted only in MEASURE or LOCKED.
  - They are issued the cycle after the offending edge.
- Capture gating:
  - cap_frame is set at a frame boundary when the FSM is LOCKED after that boundary's evaluation and iEnable = 1. It is cleared otherwise.
  - iEnable changes mid-frame have no effect until the next boundary. No partial frames are ever emitted.
- Active window (s1 stage):
  - hc in [H_SYNC_CYC+H_SYNC_BACK, H_SYNC_CYC+H_SYNC_BACK+H_ACT-1]
  - and vc in [V_SYNC_CYC+V_SYNC_BACK, V_SYNC_CYC+V_SYNC_BACK+V_ACT-1]
  - and cap_frame.
- Output coordinates:
  - oX = hc - (H_SYNC_CYC+H_SYNC_BACK)
  - oY = vc - (V_SYNC_CYC+V_SYNC_BACK)
- Latency: RGB at the input pins in cycle n appears on oPixel, with oPixel_Valid, in cycle n+2 (one input register, one output register).
- Invalid output: oPixel_Valid = 0 outside the active window. oPixel/oX/oY are then held at their last values.
- Frame pulses:
  - oFrameStart = oPixel_Valid && oX == 0 && oY == 0.
  - oFrameDone = oPixel_Valid && oX == H_ACT-1 && oY == V_ACT-1.
- Lock lost mid-frame:
  - cap_frame clears in the same cycle as the error detection.
  - oPixel_Valid is 0 from the next cycle; no oFrameDone is issued for that frame.
- Reset mid-frame: outputs clear immediately. Capture resumes only after a new SEARCH -> MEASURE -> LOCKED sequence.

Test Plan:
1. Nominal 640x480 stream (800x525, active-low syncs), iEnable = 1 from start:
   - oLocked rises at the 2nd frame boundary; oLine_Len = 800, oFrame_Lines = 525.
   - Next frame yields exactly 307200 valids, with one oFrameStart at (0,0) and one oFrameDone at (639,479).
   - Pixel data = {B,G,R} seen at the pins 2 cycles earlier.
2. Locked stream, one line stretched to 801 clocks in row 100:
   - oHErr pulses once; oLocked drops; valids stop; no oFrameDone.
   - Relock after 2 clean boundaries.
3. Frame with 524 lines while locked:
   - oVErr pulse; oFrame_Lines = 524; oLocked = 0; no capture in the next frame.
4. iEnable toggled low mid-frame, then high mid-frame:
   - Current frame completes; the next frame is not captured; capture resumes at the boundary after iEnable was high.
5. HS held inactive for 70000 clocks:
   - hc saturates; oHErr pulses; FSM returns to SEARCH.
6. iRST_n asserted mid-active line:
   - All outputs are 0 asynchronously.
   - After release, no valids appear until the 2nd clean boundary plus one frame.
